// File: rtl/riscy_pkg.sv
// Shared constants, enums and the instruction legality check for the ALU issue block.
// Optional feature: RISCY_OPIMM_EN adds acceptance of OP-IMM (I-type) instructions.
package riscy_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef enum logic [2:0] {
    F3_ADD  = 3'd0,
    F3_SLL  = 3'd1,
    F3_SLT  = 3'd2,
    F3_SLTU = 3'd3,
    F3_XOR  = 3'd4,
    F3_SRL  = 3'd5,
    F3_OR   = 3'd6,
    F3_AND  = 3'd7
  } funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } issue_state_t;

  // The alternate funct7 encoding only exists for SUB and SRA (and SRAI).
  function automatic logic is_legal(input logic [31:0] instr);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       legal;
    opc   = instr[6:0];
    f3    = instr[14:12];
    f7    = instr[31:25];
    legal = 1'b0;
    if (opc == OPC_OP) begin
      if (f7 == F7_BASE)
        legal = 1'b1;
      else if (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SRL))
        legal = 1'b1;
    end
`ifdef RISCY_OPIMM_EN
    else if (opc == OPC_OPIMM) begin
      if (f3 == F3_SLL)
        legal = (f7 == F7_BASE);
      else if (f3 == F3_SRL)
        legal = (f7 == F7_BASE) || (f7 == F7_ALT);
      else
        legal = 1'b1;
    end
`endif
    return legal;
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// 32 x XLEN architectural register file: two operand reads, one debug read,
// one shared write port; x0 is hardwired to zero.
module alu_issue_regfile
  import riscy_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      i_ra1,
  input  logic [4:0]      i_ra2,
  input  logic [4:0]      i_ra3,
  input  logic            i_we,
  input  logic [4:0]      i_wa,
  input  logic [XLEN-1:0] i_wd,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2,
  output logic [XLEN-1:0] o_rd3
);

  logic [31:0][XLEN-1:0] w_regs;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign w_regs[gi] = '0;
      end else begin : g_cell
        logic [XLEN-1:0] r_q;
        // One register per address; all clear on reset so debug reads start at zero.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)
            r_q <= '0;
          else if (i_we && i_wa == 5'(gi))
            r_q <= i_wd;
        end
        assign w_regs[gi] = r_q;
      end
    end
  endgenerate

  assign o_rd1 = w_regs[i_ra1];
  assign o_rd2 = w_regs[i_ra2];
  assign o_rd3 = w_regs[i_ra3];

endmodule

// File: rtl/alu_issue.sv
// Issue / write-back front end for a clocked ALU. One R-type op in flight:
// IDLE -> EXEC (ALU_LAT cycles) -> WB (1 cycle) -> IDLE.
// Optional feature: RISCY_OPIMM_EN also issues OP-IMM instructions with a
// sign-extended 12-bit immediate as operand B.
module alu_issue
  import riscy_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] alu_rs1,
  output logic [XLEN-1:0] alu_rs2,
  output logic [2:0]      alu_funct3,
  output logic            alu_funct7,
  input  logic [XLEN-1:0] alu_rd,
  input  logic            alu_z,
  output logic            wb_valid,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            zero,
  output logic            illegal,
  input  logic            dbg_we,
  input  logic [4:0]      dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata,
  output logic [XLEN-1:0] dbg_rdata
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  issue_state_t    r_state, w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_rs1, r_rs2, r_wb_data;
  logic [2:0]      r_f3;
  logic            r_f7, r_zero, r_illegal;
  logic [4:0]      r_rd;

  logic            w_accept, w_legal, w_f7, w_rf_we;
  logic [XLEN-1:0] w_rd1, w_rd2, w_op_b, w_rf_wd;
  logic [4:0]      w_rf_wa;

  assign w_accept = (r_state == IDLE) && instr_valid;
  assign w_legal  = is_legal(instr);

`ifdef RISCY_OPIMM_EN
  logic w_is_imm;
  assign w_is_imm = (instr[6:0] == OPC_OPIMM);
  // Immediates have no subtract form, so funct7 only matters for SRAI.
  assign w_op_b   = w_is_imm ? {{(XLEN-12){instr[31]}}, instr[31:20]} : w_rd2;
  assign w_f7     = w_is_imm ? ((instr[14:12] == F3_SRL) ? instr[30] : 1'b0) : instr[30];
`else
  assign w_op_b   = w_rd2;
  assign w_f7     = instr[30];
`endif

  // Write-back and debug writes never collide: WB only owns the port outside IDLE.
  assign w_rf_we = ((r_state == WB) && (r_rd != 5'd0)) ||
                   ((r_state == IDLE) && dbg_we && (dbg_addr != 5'd0));
  assign w_rf_wa = (r_state == WB) ? r_rd : dbg_addr;
  assign w_rf_wd = (r_state == WB) ? r_wb_data : dbg_wdata;

  alu_issue_regfile #(.XLEN(XLEN)) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .i_ra1 (instr[19:15]),
    .i_ra2 (instr[24:20]),
    .i_ra3 (dbg_addr),
    .i_we  (w_rf_we),
    .i_wa  (w_rf_wa),
    .i_wd  (w_rf_wd),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2),
    .o_rd3 (dbg_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic: leave EXEC when the latency counter has run down.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && w_legal) w_state_next = EXEC;
      EXEC:    if (r_cnt == '0)         w_state_next = WB;
      WB:      w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: operand latch on accept, result capture on the last EXEC edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_f3      <= '0;
      r_f7      <= 1'b0;
      r_rd      <= '0;
      r_cnt     <= '0;
      r_wb_data <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_legal) begin
              r_rs1 <= w_rd1;
              r_rs2 <= w_op_b;
              r_f3  <= instr[14:12];
              r_f7  <= w_f7;
              r_rd  <= instr[11:7];
              r_cnt <= CW'(ALU_LAT - 1);
            end else begin
              r_illegal <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (r_cnt == '0) begin
            r_wb_data <= alu_rd;
            r_zero    <= alu_z;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign instr_ready = (r_state == IDLE);
  assign alu_rs1     = r_rs1;
  assign alu_rs2     = r_rs2;
  assign alu_funct3  = r_f3;
  assign alu_funct7  = r_f7;
  assign wb_valid    = (r_state == WB);
  assign wb_addr     = r_rd;
  assign wb_data     = r_wb_data;
  assign zero        = r_zero;
  assign illegal     = r_illegal;

endmodule
